audio_pwm_out: RTL and testbench

AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

---
 rtl/audio_pwm_out.sv | 113 +++++++++++
 tb/tb_audio_pwm_out.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_out.sv
// Audio PWM output stage: one-entry sample buffer feeding a period-aligned duty register
// and a registered comparator PWM; define AUDIO_PWM_PDM_EN for a first-order sigma-delta bitstream instead.
module audio_pwm_out #(
    parameter int WIDTH = 8
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             amp_pwm,
    output logic             amp_sd,
    output logic             underrun
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             full_q, full_d;
    logic             pwm_q, pwm_d;
    logic             sd_q, sd_d;
    logic             wrap_s;
    logic             accept_s;
    logic             pwm_bit_s;

`ifdef AUDIO_PWM_PDM_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]   acc_sum_s;

    // Accumulator next state; the carry-out is the modulated bit
    always_comb begin
        acc_sum_s = {1'b0, acc_q} + {1'b0, duty_q};
        pwm_bit_s = acc_sum_s[WIDTH];
        if (enable) begin
            acc_d = acc_sum_s[WIDTH-1:0];
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register
    always_ff @(posedge mclk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    // Comparator PWM: high for the first duty counts of each period
    always_comb begin
        pwm_bit_s = (cnt_q < duty_q);
    end
`endif

    // Counter, buffer handshake and period-boundary duty update
    always_comb begin
        wrap_s   = enable && (cnt_q == CNT_MAX);
        accept_s = sample_valid && !full_q;
        duty_d   = duty_q;
        buf_d    = buf_q;
        full_d   = full_q;
        if (enable) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = '0;
        end
        // Wrap sees the pre-edge buffer, so a same-cycle accept never feeds it
        if (wrap_s && full_q) begin
            duty_d = buf_q;
            full_d = 1'b0;
        end else begin
            duty_d = duty_q;
        end
        if (accept_s) begin
            buf_d  = sample_in;
            full_d = 1'b1;
        end else begin
            buf_d = buf_q;
        end
        pwm_d = enable && pwm_bit_s;
        sd_d  = enable;
    end

    // State and output registers
    always_ff @(posedge mclk) begin
        if (reset) begin
            cnt_q  <= '0;
            duty_q <= '0;
            buf_q  <= '0;
            full_q <= 1'b0;
            pwm_q  <= 1'b0;
            sd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            buf_q  <= buf_d;
            full_q <= full_d;
            pwm_q  <= pwm_d;
            sd_q   <= sd_d;
        end
    end

    assign sample_ready = !full_q;
    assign amp_pwm      = pwm_q;
    assign amp_sd       = sd_q;
    assign underrun     = wrap_s && !full_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Self-checking bench for audio_pwm_out: table vectors, directed period sequences and
// randomized traffic checked cycle by cycle against a behavioural model.
module tb_audio_pwm_out;

    localparam int W      = 8;
    localparam int PERIOD = 1 << W;

    logic         mclk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] sample_in = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic         amp_pwm;
    logic         amp_sd;
    logic         underrun;

    audio_pwm_out #(.WIDTH(W)) dut (
        .mclk        (mclk),
        .reset       (reset),
        .enable      (enable),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .amp_pwm     (amp_pwm),
        .amp_sd      (amp_sd),
        .underrun    (underrun)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;
    int ones   = 0;
    int unders = 0;
    bit chk_on = 1'b0;

    // Behavioural model: position in period, active duty, FIFO of pending samples
    int m_cnt  = 0;
    int m_duty = 0;
    int m_acc  = 0;
    int m_q[$];
    int m_pwm  = 0;
    int m_sd   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_underrun(input bit en);
        return (en && m_cnt == PERIOD - 1 && m_q.size() == 0) ? 1 : 0;
    endfunction

    task automatic model_update(input bit r, input bit en, input bit v, input int s);
        bit rdy;
        if (r) begin
            m_cnt = 0; m_duty = 0; m_acc = 0; m_q.delete(); m_pwm = 0; m_sd = 0;
        end else begin
            rdy = (m_q.size() == 0);
`ifdef AUDIO_PWM_PDM_EN
            m_pwm = (en && (m_acc + m_duty) >= PERIOD) ? 1 : 0;
            if (en) m_acc = (m_acc + m_duty) % PERIOD;
`else
            m_pwm = (en && m_cnt < m_duty) ? 1 : 0;
`endif
            m_sd = en ? 1 : 0;
            if (en && m_cnt == PERIOD - 1 && m_q.size() != 0) m_duty = m_q.pop_front();
            if (v && rdy) m_q.push_back(s);
            m_cnt = en ? (m_cnt + 1) % PERIOD : 0;
        end
    endtask

    task automatic step(input bit r, input bit en, input bit v, input int s);
        @(negedge mclk);
        reset = r; enable = en; sample_valid = v; sample_in = W'(s);
        #1;
        if (chk_on) begin
            chk("sample_ready", {31'd0, sample_ready}, (m_q.size() == 0) ? 32'd1 : 32'd0);
            chk("amp_sd", {31'd0, amp_sd}, 32'(m_sd));
            chk("amp_pwm", {31'd0, amp_pwm}, 32'(m_pwm));
            chk("underrun", {31'd0, underrun}, 32'(exp_underrun(en)));
        end
        ones   += (amp_pwm === 1'b1) ? 1 : 0;
        unders += (underrun === 1'b1) ? 1 : 0;
        model_update(r, en, v, s);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic run(input int n, input bit v, input int s);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, v, s);
    endtask

    typedef struct {
        bit         r, en, v;
        logic [7:0] s;
        bit         rdy, sd, pwm, und;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int seq[3];
        int wexp[4];
        int idx;
        bit rdy;

        vecs[0] = '{r:0, en:0, v:0, s:8'h00, rdy:1, sd:0, pwm:0, und:0};
        vecs[1] = '{r:0, en:1, v:1, s:8'h40, rdy:1, sd:0, pwm:0, und:0};
        vecs[2] = '{r:0, en:1, v:0, s:8'h00, rdy:0, sd:1, pwm:0, und:0};
        vecs[3] = '{r:0, en:1, v:1, s:8'h99, rdy:0, sd:1, pwm:0, und:0};
        vecs[4] = '{r:0, en:0, v:0, s:8'h00, rdy:0, sd:1, pwm:0, und:0};
        vecs[5] = '{r:0, en:0, v:0, s:8'h00, rdy:0, sd:0, pwm:0, und:0};

        // Reset state and the first cycles out of reset, from the table
        step(1'b1, 1'b0, 1'b0, 0);
        chk_on = 1'b1;
        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge mclk);
            reset = vecs[i].r; enable = vecs[i].en;
            sample_valid = vecs[i].v; sample_in = vecs[i].s;
            #1;
            chk($sformatf("vec%0d_ready", i), {31'd0, sample_ready}, {31'd0, vecs[i].rdy});
            chk($sformatf("vec%0d_sd", i), {31'd0, amp_sd}, {31'd0, vecs[i].sd});
            chk($sformatf("vec%0d_pwm", i), {31'd0, amp_pwm}, {31'd0, vecs[i].pwm});
            chk($sformatf("vec%0d_underrun", i), {31'd0, underrun}, {31'd0, vecs[i].und});
            model_update(vecs[i].r, vecs[i].en, vecs[i].v, int'(vecs[i].s));
        end

        // Single 0x40 sample: 64 highs per period, then one underrun per period with duty held
        do_reset();
        step(1'b0, 1'b1, 1'b1, 8'h40);
        run(PERIOD - 1, 1'b0, 0);
        for (int p = 0; p < 2; p++) begin
            ones = 0; unders = 0;
            run(PERIOD, 1'b0, 0);
            chk("duty40_ones", 32'(ones), 32'd64);
            chk("duty40_underruns", 32'(unders), 32'd1);
        end

        // 0x00 then 0xFF: a period of silence, then 255 highs per period
        do_reset();
        ones = 0;
        step(1'b0, 1'b1, 1'b1, 8'h00);
        run(PERIOD - 1, 1'b1, 8'hFF);
        chk("first_period_ones", 32'(ones), 32'd0);
        wexp = '{0, 255, 255, 0};
        for (int p = 0; p < 3; p++) begin
            ones = 0;
            run(PERIOD, 1'b1, 8'hFF);
            chk($sformatf("zero_ff_period%0d", p), 32'(ones), 32'(wexp[p]));
        end

        // Valid held high through 10, 20, 30: one accepted per period, in order
        do_reset();
        seq  = '{10, 20, 30};
        wexp = '{0, 10, 20, 30};
        idx  = 0;
        for (int p = 0; p < 4; p++) begin
            ones = 0;
            for (int c = 0; c < PERIOD; c++) begin
                rdy = (m_q.size() == 0);
                step(1'b0, 1'b1, idx < 3, (idx < 3) ? seq[idx] : 0);
                if (idx < 3 && rdy) idx++;
            end
            chk($sformatf("seq_period%0d", p), 32'(ones), 32'(wexp[p]));
        end
        chk("seq_all_taken", 32'(idx), 32'd3);

        // Reset at counter 100 with the buffer full discards both duty and buffer
        do_reset();
        step(1'b0, 1'b1, 1'b1, 8'h40);
        run(PERIOD - 1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 8'hC0);
        run(99, 1'b0, 0);
        chk("full_before_reset", {31'd0, sample_ready}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 0);
        @(posedge mclk);
        #1;
        chk("rst_amp_pwm", {31'd0, amp_pwm}, 32'd0);
        chk("rst_amp_sd", {31'd0, amp_sd}, 32'd0);
        chk("rst_ready", {31'd0, sample_ready}, 32'd1);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        ones = 0;
        run(2 * PERIOD, 1'b0, 0);
        chk("discarded_sample_ones", 32'(ones), 32'd0);

        // Duty 0x80: half the cycles high in either modulator
        do_reset();
        step(1'b0, 1'b1, 1'b1, 8'h80);
        run(PERIOD - 1, 1'b0, 0);
        ones = 0;
        run(PERIOD, 1'b0, 0);
        chk("duty80_ones", 32'(ones), 32'd128);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 95,
                 $urandom_range(0, 9) < 3, int'($urandom_range(0, PERIOD - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
